// File: rtl/dda_host_link.sv
// rtl/dda_host_link.sv - byte command front end between the UART and the posit DDA core
//
// Purpose: parses host bytes into parameter-slot writes and run/halt control,
// and streams a frozen (x, y) snapshot back to the UART transmitter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rx_valid, rx_byte   one-cycle strobe and received byte
//   tx_busy             UART transmitter busy
//   tx_start, tx_byte   one-cycle transmit strobe; byte held until the next strobe
//   x, y                DDA state inputs
//   params              REG_SIZE packed N-bit slots (0=icx, 1=icy, 2=k, 3=d)
//   en_dda              DDA enable
//   cmd_err             one-cycle error pulse per offending byte
module dda_host_link #(
  parameter int N        = 16,
  parameter int REG_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic [N-1:0]          x,
  input  logic [N-1:0]          y,
  output logic [REG_SIZE*N-1:0] params,
  output logic                  en_dda,
  output logic                  cmd_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_HI  = 3'd1;
  localparam logic [2:0] S_GET_LO  = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_WAIT_LO = 3'd5;

  logic [2:0]     state;
  logic [1:0]     idx;
  logic [7:0]     shadow;
  logic [2*N-1:0] snap;
  logic [1:0]     cnt;
  logic [N-1:0]   slots [REG_SIZE];

  function automatic logic [N-1:0] reset_val(input int i);
    case (i)
      0:       reset_val = N'(16'hC000);
      1:       reset_val = N'(16'h14CD);
      default: reset_val = N'(16'h14DD);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      shadow   <= 8'd0;
      snap     <= '0;
      cnt      <= 2'd0;
      en_dda   <= 1'b1;
      tx_start <= 1'b0;
      tx_byte  <= 8'd0;
      cmd_err  <= 1'b0;
      for (int i = 0; i < REG_SIZE; i++) slots[i] <= reset_val(i);
    end else begin
      tx_start <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_byte[7:6])
              2'b00: begin
                idx   <= rx_byte[1:0];
                state <= S_GET_HI;
              end
              2'b01: begin
                snap  <= {x, y};
                cnt   <= 2'd0;
                state <= S_SEND;
              end
              2'b10:   en_dda  <= rx_byte[0];
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        S_GET_HI: begin
          if (rx_valid) begin
            shadow <= rx_byte;
            state  <= S_GET_LO;
          end
        end
        S_GET_LO: begin
          // Whole word lands in one cycle so params never shows a half-written slot.
          if (rx_valid) begin
            if (int'(idx) < REG_SIZE) slots[idx] <= N'({shadow, rx_byte});
            else                      cmd_err    <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte  <= snap[2*N-1 -: 8];
            snap     <= snap << 8;  // next byte moves to the top of the frozen snapshot
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (tx_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (rx_valid) cmd_err <= 1'b1;
          if (!tx_busy) begin
            cnt   <= cnt + 2'd1;
            state <= (cnt == 2'd3) ? S_IDLE : S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < REG_SIZE; g++) begin : g_params
    assign params[g*N +: N] = slots[g];
  end

endmodule

// File: tb/tb_dda_host_link.sv
// tb/tb_dda_host_link.sv - self-checking bench for dda_host_link
module tb_dda_host_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic [15:0] x, y;
  logic [63:0] params;
  logic        en_dda;
  logic        cmd_err;

  dda_host_link #(.N(16), .REG_SIZE(4)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .x(x), .y(y), .params(params), .en_dda(en_dda), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // UART transmitter model: busy from 2 to 11 cycles after each tx_start.
  logic [7:0] got_bytes [$];
  int pulses   = 0;
  int busy_cnt = 0;
  int cyc      = 0;
  int last_tx  = -100;
  int min_gap  = 1000;

  always @(negedge clk) begin
    cyc++;
    if (tx_start === 1'b1) begin
      got_bytes.push_back(tx_byte);
      pulses++;
      if (cyc - last_tx < min_gap) min_gap = cyc - last_tx;
      last_tx  = cyc;
      busy_cnt = 1;
    end else if (busy_cnt > 0) begin
      busy_cnt++;
      if (busy_cnt >= 12) busy_cnt = 0;
    end
    tx_busy = (busy_cnt >= 2);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget = 0;
    while (pulses < 4 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check({name, " timeout"}, 64'(budget < 400), 64'd1);
    repeat (15) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic [63:0] p;
    logic        en;
    logic        err;
  } vec_t;

  localparam logic [63:0] P_RST = {16'h14DD, 16'h14DD, 16'h14CD, 16'hC000};
  localparam logic [63:0] P_K   = {16'h14DD, 16'h3C00, 16'h14CD, 16'hC000};
  localparam logic [63:0] P_D   = {16'hABCD, 16'h3C00, 16'h14CD, 16'hC000};
  localparam logic [63:0] P_X   = {16'hABCD, 16'h3C00, 16'h14CD, 16'h1234};

  vec_t vt [12];

  initial begin
    vt[0]  = '{8'h02, P_RST, 1'b1, 1'b0};
    vt[1]  = '{8'h3C, P_RST, 1'b1, 1'b0};
    vt[2]  = '{8'h00, P_K,   1'b1, 1'b0};
    vt[3]  = '{8'h80, P_K,   1'b0, 1'b0};
    vt[4]  = '{8'h81, P_K,   1'b1, 1'b0};
    vt[5]  = '{8'hC0, P_K,   1'b1, 1'b1};
    vt[6]  = '{8'h03, P_K,   1'b1, 1'b0};
    vt[7]  = '{8'hAB, P_K,   1'b1, 1'b0};
    vt[8]  = '{8'hCD, P_D,   1'b1, 1'b0};
    vt[9]  = '{8'h00, P_D,   1'b1, 1'b0};
    vt[10] = '{8'h12, P_D,   1'b1, 1'b0};
    vt[11] = '{8'h34, P_X,   1'b1, 1'b0};

    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; x = 16'h0; y = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset params",   params,   P_RST);
    check("reset en_dda",   64'(en_dda),   64'd1);
    check("reset tx_start", 64'(tx_start), 64'd0);
    check("reset tx_byte",  64'(tx_byte),  64'd0);
    check("reset cmd_err",  64'(cmd_err),  64'd0);

    for (int i = 0; i < 12; i++) begin
      send_byte(vt[i].b);
      check($sformatf("vec%0d params", i),  params,       vt[i].p);
      check($sformatf("vec%0d en_dda", i),  64'(en_dda),  64'(vt[i].en));
      check($sformatf("vec%0d cmd_err", i), 64'(cmd_err), 64'(vt[i].err));
    end
    @(negedge clk);
    check("cmd_err single cycle", 64'(cmd_err), 64'd0);

    // READ with snapshot frozen against later x/y changes.
    x = 16'h1234; y = 16'hABCD;
    pulses = 0; got_bytes.delete();
    send_byte(8'h40);
    x = 16'h0; y = 16'h0;
    wait_done("read1");
    check("read1 pulses", 64'(pulses), 64'd4);
    if (got_bytes.size() == 4)
      check("read1 bytes", 64'({got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}), 64'h12_34_AB_CD);
    else
      check("read1 byte count", 64'(got_bytes.size()), 64'd4);
    check("tx_start spacing", 64'(min_gap >= 3), 64'd1);
    // Back in IDLE: a RUN command must be accepted.
    send_byte(8'h80);
    check("idle after read en_dda", 64'(en_dda), 64'd0);
    send_byte(8'h81);

    // READ with a stray byte during the second transmitted byte.
    x = 16'hDEAD; y = 16'hBEEF;
    pulses = 0; got_bytes.delete();
    send_byte(8'h40);
    begin
      int budget = 0;
      while (pulses < 2 && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      check("read2 reach byte2", 64'(budget < 200), 64'd1);
    end
    send_byte(8'h80);
    check("stray cmd_err", 64'(cmd_err), 64'd1);
    check("stray en_dda unchanged", 64'(en_dda), 64'd1);
    @(negedge clk);
    check("stray cmd_err drop", 64'(cmd_err), 64'd0);
    wait_done("read2");
    check("read2 pulses", 64'(pulses), 64'd4);
    if (got_bytes.size() == 4)
      check("read2 bytes", 64'({got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3]}), 64'hDE_AD_BE_EF);
    else
      check("read2 byte count", 64'(got_bytes.size()), 64'd4);

    // Reset mid-write aborts the command.
    send_byte(8'h01);
    send_byte(8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst params",   params,        P_RST);
    check("midrst en_dda",   64'(en_dda),   64'd1);
    check("midrst tx_start", 64'(tx_start), 64'd0);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    check("post-reset write", params, {16'h14DD, 16'h14DD, 16'h1122, 16'hC000});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dda_host_link.md
Name: dda_host_link

Overview:
- Byte-level command front end between the UART byte interface and the posit spring-mass DDA core.
- Parses host bytes into writes of the DDA parameter registers (icx, icy, k, d) and into run/halt control.
- On request, snapshots the DDA state (x, y) and streams it back as bytes to the UART transmitter.
- Replaces the fixed reset-only parameter file in the top level.

Parameters:
- N, 16, posit word width of parameters and state.
- REG_SIZE, 4, number of N-bit parameter slots (max 4, addressed by a 2-bit index).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe; rx_byte valid
- rx_byte  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle strobe to transmit tx_byte
- tx_byte  out  8  byte to transmit; held stable from tx_start until the next tx_start
- x  in  N  DDA state x
- y  in  N  DDA state y
- params  out  REG_SIZE*N  parameter slots packed; slot i is [i*N +: N]; slot 0=icx, 1=icy, 2=k, 3=d
- en_dda  out  1  DDA enable
- cmd_err  out  1  one-cycle error pulse

Behaviour:
- Reset values (synchronous; also applied mid-operation, aborting any command or transmission):
  - slot0=16'hC000, slot1=16'h14CD, slot2=16'h14DD, slot3=16'h14DD
  - en_dda=1, tx_start=0, tx_byte=0, cmd_err=0, FSM=IDLE
- Command byte, decoded by bits[7:6]:
  - 00 WRITE: idx=bits[1:0]; followed by hi byte, then lo byte.
  - 01 READ: stream 4 bytes: x[15:8], x[7:0], y[15:8], y[7:0].
  - 10 RUN: en_dda <= bit0, effective the cycle after the strobe.
  - 11 reserved: byte dropped, cmd_err pulses.
- FSM states: IDLE, GET_HI, GET_LO, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - rx_valid with WRITE -> GET_HI; idx latched.
  - READ -> x and y captured into a 2N-bit snapshot in the same cycle; byte counter=0; -> SEND.
  - RUN/reserved -> stay in IDLE.
- GET_HI: rx_valid -> hi byte latched into a shadow register; -> GET_LO.
- GET_LO:
  - rx_valid -> slot[idx] <= {shadow, rx_byte} in one cycle; -> IDLE.
  - If idx >= REG_SIZE: write discarded, cmd_err pulses.
  - Slots change only on the lo-byte cycle; no half-written value is ever visible on params.
- No timeout in GET_HI/GET_LO; only the next byte or rst advances.
- SEND:
  - tx_busy=0 -> tx_start=1 for one cycle, tx_byte=snapshot byte[counter]; -> WAIT_HI.
  - tx_busy=1 -> remain in SEND.
- WAIT_HI: wait until tx_busy=1 is sampled; -> WAIT_LO.
- WAIT_LO: wait until tx_busy=0; counter++; if counter was 3 -> IDLE, else -> SEND.
- Minimum spacing between tx_start pulses is 3 cycles.
- rx_valid during SEND/WAIT_HI/WAIT_LO: byte dropped, cmd_err pulses, transmission continues unaffected.
- Snapshot is frozen for the whole READ; changes on x/y after capture do not alter transmitted bytes.
- en_dda is unchanged by WRITE and READ. Writes while en_dda=1 are permitted; the DDA samples the new values at its next initial-condition load.
- cmd_err is never asserted for more than one consecutive cycle per offending byte.

Test Plan:
- Reset, no input -> params={16'h14DD,16'h14DD,16'h14CD,16'hC000} (slot3..0), en_dda=1, tx_start=0.
- Bytes 0x02, 0x3C, 0x00 -> slot2=16'h3C00 on the cycle after the third strobe; other slots unchanged; slot2 never shows 16'h3CDD or 16'h00DD in between.
- x=16'h1234, y=16'hABCD, byte 0x40; x changed to 0 right after; tx_busy model asserts 2 cycles after each tx_start for 10 cycles -> tx_byte sequence 0x12, 0x34, 0xAB, 0xCD, exactly 4 tx_start pulses, FSM back in IDLE.
- Byte 0x80 -> en_dda=0; then byte 0x81 -> en_dda=1; then byte 0xC0 -> single-cycle cmd_err, no other state change.
- Byte 0x40, then a byte strobed during the second transmitted byte -> cmd_err pulse; all 4 bytes still sent intact.
- 0x01, 0x55 then rst asserted -> slot1=16'h14CD, FSM IDLE; subsequent 0x01, 0x11, 0x22 -> slot1=16'h1122.
